spi_rx_stream: RTL and testbench

SPI_RX_STREAM -- requirements
Module: spi_rx_stream

---
 rtl/spi_pkg.sv | 24 ++
 rtl/spi_rx_fifo.sv | 66 ++++++
 rtl/spi_rx_stream.sv | 200 ++++++++++++++++++++
 tb/tb_spi_rx_stream.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI receive definitions.
//   spi_mode_t       : CPOL/CPHA mode encoding MODE0..MODE3
//   sample_on_rising : 1 when the mode samples rxd on the sclk rising edge
//   SPI_MAX_WIDTH    : largest supported word width in bits
//   SCLK_RESET       : synchroniser preset for sclk (idle level of mode 0)
package spi_pkg;

  localparam int unsigned SPI_MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    MODE0 = 2'd0,
    MODE1 = 2'd1,
    MODE2 = 2'd2,
    MODE3 = 2'd3
  } spi_mode_t;

  localparam logic SCLK_RESET = 1'b0;

  // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling edge.
  function automatic logic sample_on_rising(input spi_mode_t mode);
    return (mode == MODE0) || (mode == MODE3);
  endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// First-word-fall-through FIFO for received words.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en      : write request (ignored when full unless a read happens too)
//   wr_data    : word to store
//   full       : all DEPTH entries occupied
//   rd_en      : consume the head entry
//   rd_data    : head entry, zero when empty
//   valid      : FIFO not empty
//   level      : occupied entry count
module spi_rx_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign valid   = (count != '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign level   = count;
  assign rd_data = valid ? mem[rd_ptr] : '0;

  // A write into a full FIFO is accepted when the head is popped in the
  // same cycle; the slot being overwritten is the one being read out.
  assign do_wr = wr_en && (!full || rd_en);
  assign do_rd = rd_en && valid;

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_rx_stream.sv
// SPI slave receiver delivering words on an AXI-Stream master port.
//   clk, rst_n          : clock, asynchronous active-low reset
//   sclk, rxd, cs_n     : asynchronous SPI pins (cs_n active-low)
//   spi_mode            : CPOL/CPHA mode, latched at frame start
//   spi_word_width      : bits per word (0 or oversize = AXIS_DATA_WIDTH)
//   lsb_first           : bit order, latched at frame start
//   clear_errors        : pulse clearing the sticky error flags
//   m_axis_*            : received words, tuser marks first word of a frame
//   busy                : frame active
//   overrun_error       : sticky, word dropped on full FIFO
//   frame_error         : sticky, cs_n rose mid-word
//   fifo_level          : occupied FIFO entries
module spi_rx_stream
  import spi_pkg::*;
#(
  parameter int unsigned AXIS_DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic [AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tuser,
  input  logic                          sclk,
  input  logic                          rxd,
  input  logic                          cs_n,
  input  logic [1:0]                    spi_mode,
  input  logic [6:0]                    spi_word_width,
  input  logic                          lsb_first,
  input  logic                          clear_errors,
  output logic                          busy,
  output logic                          overrun_error,
  output logic                          frame_error,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;
  localparam logic [6:0] AXW       = 7'(AXIS_DATA_WIDTH);

  logic [SYNC_STAGES-1:0]     sclk_sync, rxd_sync, cs_sync;
  logic                       sclk_s, rxd_s, cs_s;
  logic                       sclk_prev, cs_prev;
  logic [SYNC_STAGES:0]       settle;
  logic                       armed;
  logic [0:0]                 state;
  spi_mode_t                  mode_q;
  logic                       lsb_q;
  logic [6:0]                 width_q;
  logic [6:0]                 eff_width;
  logic [6:0]                 bit_cnt;
  logic [6:0]                 bit_idx;
  logic [AXIS_DATA_WIDTH-1:0] shreg;
  logic [AXIS_DATA_WIDTH-1:0] word_next;
  logic                       first_q;
  logic                       push_q;
  logic [AXIS_DATA_WIDTH-1:0] push_data;
  logic                       push_user;
  logic                       sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic                       sample_edge, last_bit;
  logic                       fifo_full, pop;
  logic [AXIS_DATA_WIDTH:0]   fifo_dout;
  logic                       overrun_set, frame_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= {SYNC_STAGES{SCLK_RESET}};
      rxd_sync  <= '1;
      cs_sync   <= '1;
      sclk_prev <= SCLK_RESET;
      cs_prev   <= 1'b1;
      settle    <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      rxd_sync  <= {rxd_sync[SYNC_STAGES-2:0], rxd};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
      settle    <= {settle[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign rxd_s  = rxd_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];

  // The cs_n preset is 1; a pin held low through reset would otherwise look
  // like a falling edge once the chain refills, so edges are only honoured
  // after the synchroniser has been flushed with real pin values.
  assign armed = settle[SYNC_STAGES];

  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_fall   = ~cs_s & cs_prev;
  assign cs_rise   = cs_s & ~cs_prev;

  assign eff_width = ((spi_word_width == 7'd0) || (spi_word_width > AXW)) ?
                     AXW : spi_word_width;

  assign sample_edge = (state == ST_ACTIVE) &&
                       (sample_on_rising(mode_q) ? sclk_rise : sclk_fall);
  assign last_bit    = sample_edge && (bit_cnt == width_q - 7'd1);
  assign bit_idx     = lsb_q ? bit_cnt : (width_q - 7'd1 - bit_cnt);

  always_comb begin
    word_next = shreg;
    for (int unsigned b = 0; b < AXIS_DATA_WIDTH; b++) begin
      if (32'(bit_idx) == b) word_next[b] = rxd_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mode_q    <= MODE0;
      lsb_q     <= 1'b0;
      width_q   <= AXW;
      bit_cnt   <= '0;
      shreg     <= '0;
      first_q   <= 1'b0;
      push_q    <= 1'b0;
      push_data <= '0;
      push_user <= 1'b0;
    end else begin
      push_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cs_fall && armed) begin
            state   <= ST_ACTIVE;
            mode_q  <= spi_mode_t'(spi_mode);
            lsb_q   <= lsb_first;
            width_q <= eff_width;
            bit_cnt <= '0;
            shreg   <= '0;
            first_q <= 1'b1;
          end
        end
        default: begin
          if (sample_edge) begin
            if (last_bit) begin
              push_q    <= 1'b1;
              push_data <= word_next;
              push_user <= first_q;
              first_q   <= 1'b0;
              bit_cnt   <= '0;
              shreg     <= '0;
            end else begin
              shreg   <= word_next;
              bit_cnt <= bit_cnt + 7'd1;
            end
          end
          // A final sample coincident with cs_n rising still completes the word.
          if (cs_rise) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
          end
        end
      endcase
    end
  end

  assign busy = (state == ST_ACTIVE);
  assign pop  = m_axis_tvalid & m_axis_tready;

  assign overrun_set = push_q && fifo_full && !pop;
  assign frame_set   = (state == ST_ACTIVE) && cs_rise && (bit_cnt != 7'd0) && !last_bit;

  // Set takes priority over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_error <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      overrun_error <= overrun_set | (overrun_error & ~clear_errors);
      frame_error   <= frame_set   | (frame_error   & ~clear_errors);
    end
  end

  spi_rx_fifo #(
    .WIDTH (AXIS_DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push_q),
    .wr_data ({push_user, push_data}),
    .full    (fifo_full),
    .rd_en   (pop),
    .rd_data (fifo_dout),
    .valid   (m_axis_tvalid),
    .level   (fifo_level)
  );

  assign m_axis_tdata = fifo_dout[AXIS_DATA_WIDTH-1:0];
  assign m_axis_tuser = fifo_dout[AXIS_DATA_WIDTH];

endmodule

// File: tb/tb_spi_rx_stream.sv
// Directed bench for spi_rx_stream (32-bit words, 4-entry FIFO).
`timescale 1ns/1ps
module tb_spi_rx_stream;

  logic        clk;
  logic        rst_n;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tuser;
  logic        sclk;
  logic        rxd;
  logic        cs_n;
  logic [1:0]  spi_mode;
  logic [6:0]  spi_word_width;
  logic        lsb_first;
  logic        clear_errors;
  logic        busy;
  logic        overrun;
  logic        frame_err;
  logic [2:0]  level;

  int checks = 0;
  int errors = 0;

  logic [31:0] beat_data [$];
  logic        beat_user [$];

  spi_rx_stream #(
    .AXIS_DATA_WIDTH (32),
    .FIFO_DEPTH      (4),
    .SYNC_STAGES     (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .m_axis_tdata   (tdata),
    .m_axis_tvalid  (tvalid),
    .m_axis_tready  (tready),
    .m_axis_tuser   (tuser),
    .sclk           (sclk),
    .rxd            (rxd),
    .cs_n           (cs_n),
    .spi_mode       (spi_mode),
    .spi_word_width (spi_word_width),
    .lsb_first      (lsb_first),
    .clear_errors   (clear_errors),
    .busy           (busy),
    .overrun_error  (overrun),
    .frame_error    (frame_err),
    .fifo_level     (level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // tready only changes just after a rising edge, so a beat seen here is the
  // one consumed at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && tvalid && tready) begin
      beat_data.push_back(tdata);
      beat_user.push_back(tuser);
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1 tready = r;
  endtask

  task automatic send_bit(input logic b);
    logic cpol, cpha;
    cpol = spi_mode[1];
    cpha = spi_mode[0];
    if (!cpha) begin
      rxd = b;  #40;
      sclk = ~cpol; #40;
      sclk = cpol;
    end else begin
      sclk = ~cpol;
      rxd = b;  #40;
      sclk = cpol; #40;
    end
  endtask

  task automatic send_word(input logic [31:0] v, input int n, input logic lsb);
    for (int i = 0; i < n; i++) send_bit(lsb ? v[i] : v[n-1-i]);
  endtask

  task automatic frame_start(input logic [1:0] m);
    spi_mode = m;
    sclk = m[1];
    rxd = 1'b1;
    #100;
    cs_n = 1'b0;
    #40;
  endtask

  task automatic frame_end();
    #40;
    cs_n = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic wait_beats(input int n);
    for (int c = 0; c < 200 && beat_data.size() < n; c++) @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk); #1 clear_errors = 1'b1;
    @(negedge clk); #1 clear_errors = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", tvalid); end
    checks++; if (tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata got %h want 00000000", tdata); end
    checks++; if (tuser !== 1'b0) begin errors++; $display("FAIL reset_tuser got %b want 0", tuser); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_mode0_msb();
    beat_data.delete(); beat_user.delete();
    set_ready(1'b1);
    spi_word_width = 7'd8; lsb_first = 1'b0;
    frame_start(2'd0);
    send_word(32'hA5, 8, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL m0_busy_in_frame got %b want 1", busy); end
    frame_end();
    wait_beats(1);
    checks++; if (beat_data.size() !== 1) begin errors++; $display("FAIL m0_beats got %0d want 1", beat_data.size()); end
    checks++; if (beat_data[0] !== 32'hA5) begin errors++; $display("FAIL m0_tdata got %h want 000000a5", beat_data[0]); end
    checks++; if (beat_user[0] !== 1'b1) begin errors++; $display("FAIL m0_tuser got %b want 1", beat_user[0]); end
    checks++; if (overrun !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL m0_flags got %b%b want 00", overrun, frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL m0_busy_after got %b want 0", busy); end
  endtask

  task automatic test_mode3_lsb();
    beat_data.delete(); beat_user.delete();
    spi_word_width = 7'd12; lsb_first = 1'b1;
    frame_start(2'd3);
    send_word(32'h3C1, 12, 1'b1);
    send_word(32'h0F0, 12, 1'b1);
    frame_end();
    wait_beats(2);
    checks++; if (beat_data.size() !== 2) begin errors++; $display("FAIL m3_beats got %0d want 2", beat_data.size()); end
    checks++; if (beat_data[0] !== 32'h3C1 || beat_user[0] !== 1'b1) begin errors++; $display("FAIL m3_word0 got %h/%b want 000003c1/1", beat_data[0], beat_user[0]); end
    checks++; if (beat_data[1] !== 32'h0F0 || beat_user[1] !== 1'b0) begin errors++; $display("FAIL m3_word1 got %h/%b want 000000f0/0", beat_data[1], beat_user[1]); end
    lsb_first = 1'b0;
  endtask

  task automatic test_overrun();
    logic [31:0] exp_d [4];
    logic        exp_u [4];
    exp_d = '{32'h11, 32'h22, 32'h33, 32'h44};
    exp_u = '{1'b1, 1'b0, 1'b0, 1'b0};
    beat_data.delete(); beat_user.delete();
    set_ready(1'b0);
    spi_word_width = 7'd8;
    frame_start(2'd1);
    send_word(32'h11, 8, 1'b0);
    send_word(32'h22, 8, 1'b0);
    send_word(32'h33, 8, 1'b0);
    send_word(32'h44, 8, 1'b0);
    send_word(32'h55, 8, 1'b0);
    frame_end();
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovr_level got %0d want 4", level); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", overrun); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ovr_frame_err got %b want 0", frame_err); end
    set_ready(1'b1);
    wait_beats(4);
    repeat (4) @(negedge clk);
    set_ready(1'b0);
    checks++; if (beat_data.size() !== 4) begin errors++; $display("FAIL ovr_beats got %0d want 4", beat_data.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (beat_data[i] !== exp_d[i] || beat_user[i] !== exp_u[i]) begin
        errors++; $display("FAIL ovr_word%0d got %h/%b want %h/%b", i, beat_data[i], beat_user[i], exp_d[i], exp_u[i]);
      end
    end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL ovr_level_drained got %0d want 0", level); end
    pulse_clear();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_cleared got %b want 0", overrun); end
  endtask

  task automatic test_frame_error();
    logic [7:0] v;
    v = 8'h5A;
    beat_data.delete(); beat_user.delete();
    set_ready(1'b1);
    spi_word_width = 7'd8;
    frame_start(2'd2);
    for (int i = 0; i < 5; i++) send_bit(v[7-i]);
    frame_end();
    checks++; if (beat_data.size() !== 0) begin errors++; $display("FAIL fe_beats got %0d want 0", beat_data.size()); end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL fe_flag got %b want 1", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fe_busy got %b want 0", busy); end
    frame_start(2'd2);
    send_word(32'h5A, 8, 1'b0);
    frame_end();
    wait_beats(1);
    checks++; if (beat_data.size() !== 1) begin errors++; $display("FAIL fe_next_beats got %0d want 1", beat_data.size()); end
    checks++; if (beat_data[0] !== 32'h5A || beat_user[0] !== 1'b1) begin errors++; $display("FAIL fe_next_word got %h/%b want 0000005a/1", beat_data[0], beat_user[0]); end
    pulse_clear();
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL fe_cleared got %b want 0", frame_err); end
  endtask

  task automatic test_full_width();
    logic [31:0] v;
    v = 32'hDEADBEEF;
    beat_data.delete(); beat_user.delete();
    spi_word_width = 7'd0; lsb_first = 1'b0;
    frame_start(2'd0);
    for (int i = 0; i < 16; i++) send_bit(v[31-i]);
    spi_word_width = 7'd8; lsb_first = 1'b1;
    for (int i = 16; i < 32; i++) send_bit(v[31-i]);
    frame_end();
    wait_beats(1);
    lsb_first = 1'b0;
    checks++; if (beat_data.size() !== 1) begin errors++; $display("FAIL fw_beats got %0d want 1", beat_data.size()); end
    checks++; if (beat_data[0] !== 32'hDEADBEEF || beat_user[0] !== 1'b1) begin errors++; $display("FAIL fw_word got %h/%b want deadbeef/1", beat_data[0], beat_user[0]); end
    beat_data.delete(); beat_user.delete();
    spi_word_width = 7'd100;
    frame_start(2'd0);
    send_word(32'h12345678, 32, 1'b0);
    frame_end();
    wait_beats(1);
    checks++; if (beat_data.size() !== 1 || beat_data[0] !== 32'h12345678) begin errors++; $display("FAIL fw_oversize got %h (%0d beats) want 12345678 (1 beat)", beat_data[0], beat_data.size()); end
  endtask

  task automatic test_reset_mid();
    beat_data.delete(); beat_user.delete();
    set_ready(1'b0);
    spi_word_width = 7'd8; lsb_first = 1'b0;
    frame_start(2'd0);
    send_word(32'h01, 8, 1'b0);
    send_word(32'h02, 8, 1'b0);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    repeat (5) @(negedge clk);
    checks++; if (level !== 3'd2) begin errors++; $display("FAIL rm_level_before got %0d want 2", level); end
    rst_n = 1'b0;
    #1;
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL rm_tvalid got %b want 0", tvalid); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL rm_level got %0d want 0", level); end
    cs_n = 1'b1; sclk = 1'b0;
    #50;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    set_ready(1'b1);
    frame_start(2'd0);
    send_word(32'h77, 8, 1'b0);
    frame_end();
    wait_beats(1);
    checks++; if (beat_data.size() !== 1) begin errors++; $display("FAIL rm_beats got %0d want 1", beat_data.size()); end
    checks++; if (beat_data[0] !== 32'h77 || beat_user[0] !== 1'b1) begin errors++; $display("FAIL rm_word got %h/%b want 00000077/1", beat_data[0], beat_user[0]); end
  endtask

  initial begin
    rst_n = 1'b0;
    tready = 1'b0;
    sclk = 1'b0;
    rxd = 1'b1;
    cs_n = 1'b1;
    spi_mode = 2'd0;
    spi_word_width = 7'd8;
    lsb_first = 1'b0;
    clear_errors = 1'b0;
    test_reset();
    test_mode0_msb();
    test_mode3_lsb();
    test_overrun();
    test_frame_error();
    test_full_width();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
